// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline stage register numbers and controls in, stall/flush/forward controls out.
// PIPE_HAZARD_PERF_EN adds the stallCycles/flushCount performance outputs.
interface pipe_hazard_ctrl_if;
   localparam int unsigned RW = 4;
   localparam int unsigned PW = 16;

   logic [RW-1:0] ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W;
   logic          memToRegE, regWriteM, regWriteW, branchTakenE, memReq, memReady;
   logic          stallF, stallD, stallE, stallM;
   logic          flushD, flushE, flushW;
   logic [1:0]    fwdAE, fwdBE;
   logic          memErr;
`ifdef PIPE_HAZARD_PERF_EN
   logic [PW-1:0] stallCycles, flushCount;
`endif

   modport master (
      output ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W,
      output memToRegE, regWriteM, regWriteW, branchTakenE, memReq, memReady,
      input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
      input  fwdAE, fwdBE, memErr
`ifdef PIPE_HAZARD_PERF_EN
      , input stallCycles, flushCount
`endif
   );

   modport slave (
      input  ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3W,
      input  memToRegE, regWriteM, regWriteW, branchTakenE, memReq, memReady,
      output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
      output fwdAE, fwdBE, memErr
`ifdef PIPE_HAZARD_PERF_EN
      , output stallCycles, flushCount
`endif
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch bubbles, data-memory wait with timeout abort.
// Optional perf counters under `PIPE_HAZARD_PERF_EN`.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave hz
);
   localparam int unsigned CW = 8;
   localparam int unsigned RW = 4;
   localparam logic [RW-1:0] R15 = RW'(15);
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(MEM_TIMEOUT);

   typedef enum logic {RUN, MEMWAIT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          load_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Outputs are same-cycle controls; reset forces every control to its idle value.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      hz.stallF    = 1'b0;
      hz.stallD    = 1'b0;
      hz.stallE    = 1'b0;
      hz.stallM    = 1'b0;
      hz.flushD    = 1'b0;
      hz.flushE    = 1'b0;
      hz.flushW    = 1'b0;
      hz.memErr    = 1'b0;
      hz.fwdAE     = 2'b00;
      hz.fwdBE     = 2'b00;
      load_use     = hz.memToRegE && (hz.wa3E != R15) &&
                     ((hz.wa3E == hz.ra1D) || (hz.wa3E == hz.ra2D));

      if (!rst) begin
         if (hz.regWriteM && (hz.wa3M == hz.ra1E) && (hz.wa3M != R15))      hz.fwdAE = 2'b10;
         else if (hz.regWriteW && (hz.wa3W == hz.ra1E) && (hz.wa3W != R15)) hz.fwdAE = 2'b01;
         if (hz.regWriteM && (hz.wa3M == hz.ra2E) && (hz.wa3M != R15))      hz.fwdBE = 2'b10;
         else if (hz.regWriteW && (hz.wa3W == hz.ra2E) && (hz.wa3W != R15)) hz.fwdBE = 2'b01;

         case (state)
            RUN: begin
               wait_cnt_nxt = '0;
               if (hz.memReq && !hz.memReady) begin
                  state_nxt = MEMWAIT;
                  hz.stallF = 1'b1;
                  hz.stallD = 1'b1;
                  hz.stallE = 1'b1;
                  hz.stallM = 1'b1;
                  hz.flushW = 1'b1;
               end else if (hz.branchTakenE) begin
                  hz.flushD = 1'b1;
                  hz.flushE = 1'b1;
               end else if (load_use) begin
                  hz.stallF = 1'b1;
                  hz.stallD = 1'b1;
                  hz.flushE = 1'b1;
               end
            end
            MEMWAIT: begin
               // Ready beats a coincident timeout; branch and load-use wait for RUN.
               if (hz.memReady) begin
                  state_nxt    = RUN;
                  wait_cnt_nxt = '0;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  state_nxt    = RUN;
                  wait_cnt_nxt = '0;
                  hz.memErr    = 1'b1;
                  hz.flushD    = 1'b1;
                  hz.flushE    = 1'b1;
               end else begin
                  wait_cnt_nxt = wait_cnt + CW'(1);
                  hz.stallF    = 1'b1;
                  hz.stallD    = 1'b1;
                  hz.stallE    = 1'b1;
                  hz.stallM    = 1'b1;
                  hz.flushW    = 1'b1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   localparam int unsigned PW = 16;
   logic [PW-1:0] stall_cycles, flush_count;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (hz.stallF && (stall_cycles != '1))
            stall_cycles <= stall_cycles + PW'(1);
         if ((hz.flushD || hz.flushE) && (flush_count != '1))
            flush_count <= flush_count + PW'(1);
      end
   end

   assign hz.stallCycles = stall_cycles;
   assign hz.flushCount  = flush_count;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); expected controls queued per step and checked mid-cycle.
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if bus();
   pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .hz(bus));

   logic [11:0] exp_q[$];
   int checks = 0;
   int passed = 0;
   int fails  = 0;
`ifdef PIPE_HAZARD_PERF_EN
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;
`endif

   // Packing: {stallF,stallD,stallE,stallM, flushD,flushE,flushW, fwdAE, fwdBE, memErr}
   function automatic logic [11:0] ev(input logic [3:0] st, input logic [2:0] fl,
                                      input logic [1:0] fa, input logic [1:0] fb, input logic err);
      return {st, fl, fa, fb, err};
   endfunction

   function automatic logic [11:0] observed();
      return {bus.stallF, bus.stallD, bus.stallE, bus.stallM,
              bus.flushD, bus.flushE, bus.flushW, bus.fwdAE, bus.fwdBE, bus.memErr};
   endfunction

   task automatic expect_out(input logic [11:0] e, input string tag);
      logic [11:0] o, x;
      exp_q.push_back(e);
      @(negedge clk);
      x = exp_q.pop_front();
      o = observed();
      checks++;
      assert (o === x) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, o, x);
      end
`ifdef PIPE_HAZARD_PERF_EN
      checks++;
      assert (bus.stallCycles === 16'(m_stall)) passed++;
      else begin
         fails++;
         $error("FAIL %s.stallCycles observed=%0d expected=%0d", tag, bus.stallCycles, m_stall);
      end
      checks++;
      assert (bus.flushCount === 16'(m_flush)) passed++;
      else begin
         fails++;
         $error("FAIL %s.flushCount observed=%0d expected=%0d", tag, bus.flushCount, m_flush);
      end
      if (rst) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (x[11] && m_stall < 32'hFFFF) m_stall++;
         if ((x[7] || x[6]) && m_flush < 32'hFFFF) m_flush++;
      end
`endif
      @(posedge clk);
      #1;
   endtask

   localparam logic [3:0] SALL = 4'b1111;
   localparam logic [3:0] SFD  = 4'b1100;
   localparam logic [3:0] S0   = 4'b0000;
   localparam logic [2:0] FW   = 3'b001;
   localparam logic [2:0] FE   = 3'b010;
   localparam logic [2:0] FDE  = 3'b110;
   localparam logic [2:0] F0   = 3'b000;

   initial begin
      rst = 1'b1;
      bus.ra1D = 4'd0; bus.ra2D = 4'd0; bus.ra1E = 4'd0; bus.ra2E = 4'd0;
      bus.wa3E = 4'd0; bus.wa3M = 4'd0; bus.wa3W = 4'd0;
      bus.memToRegE = 1'b0; bus.regWriteM = 1'b0; bus.regWriteW = 1'b0;
      bus.branchTakenE = 1'b1; bus.memReq = 1'b1; bus.memReady = 1'b0;

      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "reset");
      rst = 1'b0; bus.branchTakenE = 1'b0; bus.memReq = 1'b0;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "idle");

      // Forwarding priority and r15 exclusion
      bus.wa3M = 4'd3; bus.regWriteM = 1'b1; bus.wa3W = 4'd3; bus.regWriteW = 1'b1; bus.ra1E = 4'd3;
      expect_out(ev(S0, F0, 2'b10, 2'b00, 1'b0), "fwdA_mem");
      bus.wa3M = 4'd15;
      expect_out(ev(S0, F0, 2'b01, 2'b00, 1'b0), "fwdA_wb");
      bus.wa3M = 4'd3; bus.ra2E = 4'd3;
      expect_out(ev(S0, F0, 2'b10, 2'b10, 1'b0), "fwdAB_mem");
      bus.regWriteM = 1'b0; bus.wa3W = 4'd15; bus.ra1E = 4'd15;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "fwd_r15");
      bus.regWriteW = 1'b0; bus.ra1E = 4'd0; bus.ra2E = 4'd0;

      // Load-use bubble, r15 exclusion, branch override
      bus.memToRegE = 1'b1; bus.wa3E = 4'd5; bus.ra2D = 4'd5;
      expect_out(ev(SFD, FE, 2'b00, 2'b00, 1'b0), "loaduse");
      bus.memToRegE = 1'b0; bus.wa3E = 4'd7;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "loaduse_next");
      bus.memToRegE = 1'b1; bus.wa3E = 4'd15; bus.ra1D = 4'd15;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "loaduse_r15");
      bus.wa3E = 4'd5; bus.ra1D = 4'd0; bus.branchTakenE = 1'b1;
      expect_out(ev(S0, FDE, 2'b00, 2'b00, 1'b0), "branch_over_lu");

      // Memory wait: 3 low-ready cycles, then ready; hazards ignored while waiting
      bus.memReq = 1'b1; bus.memReady = 1'b0;
      expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "mw_enter");
      expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "mw_ignore_br");
      bus.branchTakenE = 1'b0; bus.memToRegE = 1'b0;
      expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "mw_3");
      bus.memReady = 1'b1;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "mw_ready");
      bus.memReq = 1'b0; bus.memReady = 1'b0; bus.branchTakenE = 1'b1;
      expect_out(ev(S0, FDE, 2'b00, 2'b00, 1'b0), "br_after_mw");
      bus.branchTakenE = 1'b0;

      // Timeout abort
      bus.memReq = 1'b1;
      expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "to_enter");
      for (int i = 0; i < 4; i++) expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "to_wait");
      expect_out(ev(S0, FDE, 2'b00, 2'b00, 1'b1), "to_abort");
      bus.memReq = 1'b0;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "to_run");

      // Ready coincident with timeout: ready wins
      bus.memReq = 1'b1;
      expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "tie_enter");
      for (int i = 0; i < 4; i++) expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "tie_wait");
      bus.memReady = 1'b1;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "tie_ready");
      bus.memReq = 1'b0; bus.memReady = 1'b0;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "tie_run");

      // Ready without request is ignored
      bus.memReady = 1'b1;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "ready_noreq");
      bus.memReady = 1'b0;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "ready_noreq_next");

      // Reset in second wait cycle
      bus.memReq = 1'b1;
      expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "rst_mw_enter");
      expect_out(ev(SALL, FW, 2'b00, 2'b00, 1'b0), "rst_mw_1");
      rst = 1'b1;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "rst_mw_rst");
      rst = 1'b0; bus.memReq = 1'b0;
      expect_out(ev(S0, F0, 2'b00, 2'b00, 1'b0), "rst_mw_run");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
